// File: rtl/nn_stage_out_ctrl.sv
// Output/memory controller for one NN stage: memory port drive, delayed tap write-back,
// error-output valid and stage output. Optional 2-entry skid buffer: NN_STAGE_OUT_SKID_EN.
module nn_stage_out_ctrl #(
  parameter int WORD_W   = 32,
  parameter int NTAPS    = 6,
  parameter int TAP_AW   = 4,
  parameter int DATA_AW  = 6,
  parameter int PHASE_W  = 2,
  parameter int ERR_BASE = 12,
  parameter int TAP_LAT  = 5,
  parameter int ERR_LAT  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_active,
  input  logic                      i_active_pre,
  input  logic                      i_active_normal,
  input  logic                      i_active_start_d,
  input  logic                      i_data_valid,
  input  logic [DATA_AW-1:0]        i_data_write_addr,
  input  logic [WORD_W-1:0]         i_data_value,
  input  logic [DATA_AW-1:0]        i_data_read_addr,
  input  logic [TAP_AW-1:0]         i_tap_address,
  input  logic                      i_tap_enable,
  input  logic                      i_bias_enable,
  input  logic [TAP_AW-1:0]         i_bias_wr_address,
  input  logic                      i_error_update_first,
  input  logic                      i_error_update_latch,
  input  logic                      i_error_tap_update_out,
  input  logic                      i_error_valid,
  input  logic [PHASE_W-1:0]        i_error_phase,
  input  logic [PHASE_W-1:0]        i_error_phase_read,
  input  logic [31:0]               i_error_sub_address,
  input  logic [WORD_W-1:0]         i_error_value,
  input  logic [WORD_W-1:0]         i_st_data_out,
  input  logic [WORD_W-1:0]         i_st_data_out_pre,
  input  logic [WORD_W-1:0]         i_st_data_out_bias,
  input  logic [NTAPS*WORD_W-1:0]   i_st_tap_out,
  input  logic [NTAPS*WORD_W-1:0]   i_tap_rd_data,
  input  logic [WORD_W-1:0]         i_data_rd_data,
  input  logic [WORD_W-1:0]         i_bias_rd_data,
  output logic                      o_data_wr_vld,
  output logic [DATA_AW-1:0]        o_data_wr_addr,
  output logic [WORD_W-1:0]         o_data_wr_data,
  output logic                      o_data_rd_vld,
  output logic [DATA_AW-1:0]        o_data_rd_addr,
  output logic                      o_tap_rd_vld,
  output logic [TAP_AW-1:0]         o_tap_rd_addr,
  output logic                      o_tap_wr_vld,
  output logic [TAP_AW-1:0]         o_tap_wr_addr,
  output logic [NTAPS*WORD_W-1:0]   o_tap_wr_data,
  output logic                      o_tap_sub_vld,
  output logic [31:0]               o_tap_sub_addr,
  output logic [WORD_W-1:0]         o_tap_sub_data,
  output logic                      o_bias_rd_vld,
  output logic                      o_bias_wr_vld,
  output logic [TAP_AW-1:0]         o_bias_rd_addr,
  output logic [TAP_AW-1:0]         o_bias_wr_addr,
  output logic [WORD_W-1:0]         o_bias_wr_data,
  output logic [NTAPS*WORD_W-1:0]   o_taps,
  output logic [WORD_W-1:0]         o_st_data,
  output logic [WORD_W-1:0]         o_st_bias,
  output logic [WORD_W-1:0]         o_out_data,
  output logic                      o_out_vld,
  input  logic                      i_out_rdy,
  output logic [WORD_W-1:0]         o_out_pre,
  output logic                      o_out_pre_vld,
  output logic [WORD_W-1:0]         o_zerror,
  output logic                      o_zerror_vld,
  output logic                      o_wb_collision,
  output logic                      o_out_overflow
);

  localparam logic [TAP_AW-1:0] ERR_BASE_A = TAP_AW'(ERR_BASE);

  logic                w_wb;
  logic [TAP_AW-1:0]   w_tap_rd_addr;
  logic [TAP_AW-1:0]   w_err_rd_addr;
  logic [TAP_AW-1:0]   w_err_wr_addr;
  logic [TAP_LAT:1]    r_wb_d;
  logic [TAP_LAT:1]    r_upd_d;
  logic [TAP_AW-1:0]   r_addr_d [1:TAP_LAT];
  logic [ERR_LAT:1]    r_upd_e;
  logic                r_first_d;
  logic                r_wb_collision;

  assign w_wb          = i_error_update_latch & ~i_error_update_first;
  assign w_err_rd_addr = ERR_BASE_A + TAP_AW'(i_error_phase_read);
  assign w_err_wr_addr = ERR_BASE_A + TAP_AW'(i_error_phase);
  assign w_tap_rd_addr = i_error_update_first ? w_err_rd_addr : i_tap_address;

  assign o_data_wr_vld  = i_data_valid;
  assign o_data_wr_addr = i_data_write_addr;
  assign o_data_wr_data = i_data_value;
  assign o_data_rd_vld  = i_active_normal;
  assign o_data_rd_addr = i_data_read_addr;

  assign o_tap_rd_vld   = i_active_normal;
  assign o_tap_rd_addr  = w_tap_rd_addr;
  assign o_bias_rd_vld  = i_active_normal;
  assign o_bias_rd_addr = i_tap_address;

  // A matured write-back owns the tap write port; the error sub-write yields to it.
  assign o_tap_wr_addr  = r_wb_d[TAP_LAT] ? r_addr_d[TAP_LAT] : w_err_wr_addr;
  assign o_tap_wr_vld   = i_error_valid | (i_tap_enable & r_wb_d[TAP_LAT] & ~r_upd_d[TAP_LAT]);
  assign o_tap_wr_data  = i_st_tap_out;
  assign o_tap_sub_vld  = r_wb_d[TAP_LAT] ? 1'b0 : i_error_valid;
  assign o_tap_sub_addr = i_error_sub_address;
  assign o_tap_sub_data = i_error_value;

  assign o_bias_wr_vld  = i_bias_enable & r_wb_d[TAP_LAT-1];
  assign o_bias_wr_addr = i_bias_wr_address;
  assign o_bias_wr_data = i_st_data_out_bias;

  for (genvar i = 0; i < NTAPS; i++) begin : g_taps
    assign o_taps[i*WORD_W +: WORD_W] = i_tap_rd_data[i*WORD_W +: WORD_W];
  end
  assign o_st_data = i_data_rd_data;
  assign o_st_bias = i_bias_rd_data;

  assign o_out_pre      = i_st_data_out_pre;
  assign o_out_pre_vld  = i_active_pre;
  assign o_zerror       = i_st_data_out_pre;
  assign o_zerror_vld   = r_upd_e[ERR_LAT] & ~r_first_d;
  assign o_wb_collision = r_wb_collision;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_d         <= '0;
      r_upd_d        <= '0;
      r_upd_e        <= '0;
      r_first_d      <= 1'b0;
      r_wb_collision <= 1'b0;
      for (int k = 1; k <= TAP_LAT; k++) r_addr_d[k] <= '0;
    end else begin
      r_wb_d[1]   <= w_wb;
      r_upd_d[1]  <= i_error_tap_update_out;
      r_addr_d[1] <= w_tap_rd_addr;
      for (int k = 2; k <= TAP_LAT; k++) begin
        r_wb_d[k]   <= r_wb_d[k-1];
        r_upd_d[k]  <= r_upd_d[k-1];
        r_addr_d[k] <= r_addr_d[k-1];
      end
      r_upd_e[1] <= i_error_tap_update_out;
      for (int k = 2; k <= ERR_LAT; k++) r_upd_e[k] <= r_upd_e[k-1];
      r_first_d <= i_active_start_d;
      if (i_error_valid && r_wb_d[TAP_LAT]) r_wb_collision <= 1'b1;
    end
  end

`ifdef NN_STAGE_OUT_SKID_EN
  logic [WORD_W-1:0] r_buf0;
  logic [WORD_W-1:0] r_buf1;
  logic [1:0]        r_count;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;

  assign w_push         = i_active;
  assign w_pop          = (r_count != 2'd0) & i_out_rdy;
  assign o_out_data     = r_buf0;
  assign o_out_vld      = (r_count != 2'd0);
  assign o_out_overflow = r_overflow;

  // r_buf0 is always the head; a full buffer accepts a push only when it pops in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_count    <= 2'd0;
      r_overflow <= 1'b0;
    end else if (w_push && w_pop) begin
      if (r_count == 2'd1) begin
        r_buf0 <= i_st_data_out;
      end else begin
        r_buf0 <= r_buf1;
        r_buf1 <= i_st_data_out;
      end
    end else if (w_pop) begin
      r_buf0  <= r_buf1;
      r_count <= r_count - 2'd1;
    end else if (w_push) begin
      if (r_count == 2'd0) begin
        r_buf0  <= i_st_data_out;
        r_count <= 2'd1;
      end else if (r_count == 2'd1) begin
        r_buf1  <= i_st_data_out;
        r_count <= 2'd2;
      end else begin
        r_overflow <= 1'b1;
      end
    end
  end
`else
  logic w_unused_rdy;

  assign w_unused_rdy   = i_out_rdy;
  assign o_out_data     = i_st_data_out;
  assign o_out_vld      = i_active;
  assign o_out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_nn_stage_out_ctrl.sv
// Self-checking bench for nn_stage_out_ctrl at default parameters; the skid-buffer
// scenario is exercised only when NN_STAGE_OUT_SKID_EN is defined.
module tb_nn_stage_out_ctrl;

  localparam int WORD_W  = 32;
  localparam int NTAPS   = 6;
  localparam int TAP_AW  = 4;
  localparam int DATA_AW = 6;
  localparam int PHASE_W = 2;
  localparam int TAP_LAT = 5;
  localparam int ERR_LAT = 10;

  logic clk = 1'b0;
  logic reset;
  logic i_active, i_active_pre, i_active_normal, i_active_start_d;
  logic i_data_valid;
  logic [DATA_AW-1:0] i_data_write_addr, i_data_read_addr;
  logic [WORD_W-1:0] i_data_value;
  logic [TAP_AW-1:0] i_tap_address, i_bias_wr_address;
  logic i_tap_enable, i_bias_enable;
  logic i_error_update_first, i_error_update_latch, i_error_tap_update_out, i_error_valid;
  logic [PHASE_W-1:0] i_error_phase, i_error_phase_read;
  logic [31:0] i_error_sub_address;
  logic [WORD_W-1:0] i_error_value, i_st_data_out, i_st_data_out_pre, i_st_data_out_bias;
  logic [NTAPS*WORD_W-1:0] i_st_tap_out, i_tap_rd_data;
  logic [WORD_W-1:0] i_data_rd_data, i_bias_rd_data;
  logic o_data_wr_vld, o_data_rd_vld, o_tap_rd_vld, o_tap_wr_vld, o_tap_sub_vld;
  logic [DATA_AW-1:0] o_data_wr_addr, o_data_rd_addr;
  logic [WORD_W-1:0] o_data_wr_data;
  logic [TAP_AW-1:0] o_tap_rd_addr, o_tap_wr_addr, o_bias_rd_addr, o_bias_wr_addr;
  logic [NTAPS*WORD_W-1:0] o_tap_wr_data, o_taps;
  logic [31:0] o_tap_sub_addr;
  logic [WORD_W-1:0] o_tap_sub_data, o_bias_wr_data, o_st_data, o_st_bias;
  logic o_bias_rd_vld, o_bias_wr_vld;
  logic [WORD_W-1:0] o_out_data, o_out_pre, o_zerror;
  logic o_out_vld, i_out_rdy, o_out_pre_vld, o_zerror_vld, o_wb_collision, o_out_overflow;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    int              cyc;
    logic [TAP_AW-1:0] addr;
  } wbExp_t;

  wbExp_t wbQ[$];
  int     biasQ[$];
  int     zerrQ[$];
  logic [WORD_W-1:0] outQ[$];

  nn_stage_out_ctrl dut (
    .clk(clk), .reset(reset),
    .i_active(i_active), .i_active_pre(i_active_pre), .i_active_normal(i_active_normal),
    .i_active_start_d(i_active_start_d),
    .i_data_valid(i_data_valid), .i_data_write_addr(i_data_write_addr), .i_data_value(i_data_value),
    .i_data_read_addr(i_data_read_addr),
    .i_tap_address(i_tap_address), .i_tap_enable(i_tap_enable), .i_bias_enable(i_bias_enable),
    .i_bias_wr_address(i_bias_wr_address),
    .i_error_update_first(i_error_update_first), .i_error_update_latch(i_error_update_latch),
    .i_error_tap_update_out(i_error_tap_update_out), .i_error_valid(i_error_valid),
    .i_error_phase(i_error_phase), .i_error_phase_read(i_error_phase_read),
    .i_error_sub_address(i_error_sub_address), .i_error_value(i_error_value),
    .i_st_data_out(i_st_data_out), .i_st_data_out_pre(i_st_data_out_pre),
    .i_st_data_out_bias(i_st_data_out_bias), .i_st_tap_out(i_st_tap_out),
    .i_tap_rd_data(i_tap_rd_data), .i_data_rd_data(i_data_rd_data), .i_bias_rd_data(i_bias_rd_data),
    .o_data_wr_vld(o_data_wr_vld), .o_data_wr_addr(o_data_wr_addr), .o_data_wr_data(o_data_wr_data),
    .o_data_rd_vld(o_data_rd_vld), .o_data_rd_addr(o_data_rd_addr),
    .o_tap_rd_vld(o_tap_rd_vld), .o_tap_rd_addr(o_tap_rd_addr),
    .o_tap_wr_vld(o_tap_wr_vld), .o_tap_wr_addr(o_tap_wr_addr), .o_tap_wr_data(o_tap_wr_data),
    .o_tap_sub_vld(o_tap_sub_vld), .o_tap_sub_addr(o_tap_sub_addr), .o_tap_sub_data(o_tap_sub_data),
    .o_bias_rd_vld(o_bias_rd_vld), .o_bias_wr_vld(o_bias_wr_vld),
    .o_bias_rd_addr(o_bias_rd_addr), .o_bias_wr_addr(o_bias_wr_addr), .o_bias_wr_data(o_bias_wr_data),
    .o_taps(o_taps), .o_st_data(o_st_data), .o_st_bias(o_st_bias),
    .o_out_data(o_out_data), .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy),
    .o_out_pre(o_out_pre), .o_out_pre_vld(o_out_pre_vld),
    .o_zerror(o_zerror), .o_zerror_vld(o_zerror_vld),
    .o_wb_collision(o_wb_collision), .o_out_overflow(o_out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change at posedge+1; every task starts and ends at that point.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) nextCycle();
  endtask

  task automatic clearInputs();
    i_active = 0; i_active_pre = 0; i_active_normal = 0; i_active_start_d = 0;
    i_data_valid = 0; i_data_write_addr = '0; i_data_value = '0; i_data_read_addr = '0;
    i_tap_address = '0; i_tap_enable = 0; i_bias_enable = 0; i_bias_wr_address = '0;
    i_error_update_first = 0; i_error_update_latch = 0; i_error_tap_update_out = 0;
    i_error_valid = 0; i_error_phase = '0; i_error_phase_read = '0;
    i_error_sub_address = '0; i_error_value = '0;
    i_st_data_out = '0; i_st_data_out_pre = '0; i_st_data_out_bias = '0; i_st_tap_out = '0;
    i_tap_rd_data = '0; i_data_rd_data = '0; i_bias_rd_data = '0; i_out_rdy = 0;
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    checkCount++;
    if ({o_tap_wr_vld, o_tap_sub_vld, o_bias_wr_vld, o_zerror_vld} !== 4'b0000) begin
      failCount++;
      $display("[TB] FAIL reset_valids: got %b, required 0000",
               {o_tap_wr_vld, o_tap_sub_vld, o_bias_wr_vld, o_zerror_vld});
    end
    checkCount++;
    if ({o_wb_collision, o_out_overflow, o_out_vld} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %b, required 000", {o_wb_collision, o_out_overflow, o_out_vld});
    end
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_tap_read();
    logic [NTAPS*WORD_W-1:0] pattern;
    pattern = {6{32'h0}};
    for (int i = 0; i < NTAPS; i++) pattern[i*WORD_W +: WORD_W] = 32'h1000_0000 + i * 32'h111;
    i_tap_address = 4'd3; i_active_normal = 1; i_tap_rd_data = pattern;
    i_data_rd_data = 32'hDA7A_0001; i_bias_rd_data = 32'hB1A5_0002;
    #1;
    checkCount++;
    if (o_tap_rd_addr !== 4'd3 || o_tap_rd_vld !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL tap_rd_normal: got addr=%0d vld=%b, required addr=3 vld=1", o_tap_rd_addr, o_tap_rd_vld);
    end
    checkCount++;
    if (o_bias_rd_addr !== 4'd3 || o_bias_rd_vld !== 1'b1 || o_data_rd_vld !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL bias_rd: got addr=%0d vld=%b data_rd_vld=%b, required 3 1 1",
               o_bias_rd_addr, o_bias_rd_vld, o_data_rd_vld);
    end
    checkCount++;
    if (o_taps !== pattern || o_st_data !== 32'hDA7A_0001 || o_st_bias !== 32'hB1A5_0002) begin
      failCount++;
      $display("[TB] FAIL operands: got st_data=%h st_bias=%h, required DA7A0001 B1A50002", o_st_data, o_st_bias);
    end
    i_error_update_first = 1; i_error_phase_read = 2'd2;
    #1;
    checkCount++;
    if (o_tap_rd_addr !== 4'd14) begin
      failCount++;
      $display("[TB] FAIL tap_rd_err: got addr=%0d, required 14", o_tap_rd_addr);
    end
    i_data_valid = 1; i_data_write_addr = 6'd45; i_data_value = 32'hCAFE_F00D; i_data_read_addr = 6'd17;
    #1;
    checkCount++;
    if (o_data_wr_vld !== 1'b1 || o_data_wr_addr !== 6'd45 || o_data_wr_data !== 32'hCAFE_F00D ||
        o_data_rd_addr !== 6'd17) begin
      failCount++;
      $display("[TB] FAIL data_port: got vld=%b waddr=%0d wdata=%h raddr=%0d, required 1 45 cafef00d 17",
               o_data_wr_vld, o_data_wr_addr, o_data_wr_data, o_data_rd_addr);
    end
    clearInputs();
    nextCycle();
  endtask

  task automatic test_writeback();
    wbExp_t e;
    int     b;
    logic   expVld;
    i_tap_enable = 1; i_bias_enable = 1; i_error_phase = 2'd1;
    i_bias_wr_address = 4'd2; i_st_data_out_bias = 32'h0B1A_5000;
    i_st_tap_out = {6{32'h7A70_0000}};
    for (int cyc = 0; cyc < 13; cyc++) begin
      i_error_update_latch = 0; i_error_tap_update_out = 0;
      if (cyc == 0 || cyc == 2 || cyc == 4) begin
        i_error_update_latch = 1;
        i_tap_address = (cyc == 0) ? 4'd7 : (cyc == 2) ? 4'd9 : 4'd5;
        i_error_tap_update_out = (cyc == 4);
        if (cyc != 4) wbQ.push_back('{cyc + TAP_LAT, i_tap_address});
        biasQ.push_back(cyc + TAP_LAT - 1);
      end
      @(negedge clk);
      expVld = (wbQ.size() > 0) && (wbQ[0].cyc == cyc);
      checkCount++;
      if (o_tap_wr_vld !== expVld) begin
        failCount++;
        $display("[TB] FAIL wb_vld cyc%0d: got %b, required %b", cyc, o_tap_wr_vld, expVld);
      end
      if (expVld) begin
        e = wbQ.pop_front();
        checkCount++;
        if (o_tap_wr_addr !== e.addr || o_tap_wr_data !== {6{32'h7A70_0000}}) begin
          failCount++;
          $display("[TB] FAIL wb_addr cyc%0d: got %0d, required %0d", cyc, o_tap_wr_addr, e.addr);
        end
      end
      expVld = (biasQ.size() > 0) && (biasQ[0] == cyc);
      checkCount++;
      if (o_bias_wr_vld !== expVld) begin
        failCount++;
        $display("[TB] FAIL bias_wr_vld cyc%0d: got %b, required %b", cyc, o_bias_wr_vld, expVld);
      end
      if (expVld) begin
        b = biasQ.pop_front();
        checkCount++;
        if (o_bias_wr_addr !== 4'd2 || o_bias_wr_data !== 32'h0B1A_5000) begin
          failCount++;
          $display("[TB] FAIL bias_wr_data cyc%0d: got addr=%0d data=%h, required 2 0b1a5000",
                   b, o_bias_wr_addr, o_bias_wr_data);
        end
      end
      if (cyc == 11) begin
        checkCount++;
        if (o_tap_wr_addr !== 4'd13) begin
          failCount++;
          $display("[TB] FAIL wr_addr_idle: got %0d, required 13", o_tap_wr_addr);
        end
      end
      nextCycle();
    end
    checkCount++;
    if (wbQ.size() != 0 || biasQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL wb_drain: got %0d/%0d pending, required 0/0", wbQ.size(), biasQ.size());
    end
    clearInputs();
    idle(12);
  endtask

  task automatic test_zerror();
    logic expVld;
    for (int pass = 0; pass < 2; pass++) begin
      i_active_start_d = (pass == 1);
      i_st_data_out_pre = 32'h2E44_0000 + pass;
      nextCycle();
      for (int cyc = 0; cyc < 14; cyc++) begin
        i_error_tap_update_out = (cyc == 0);
        if (cyc == 0 && pass == 0) zerrQ.push_back(cyc + ERR_LAT);
        @(negedge clk);
        expVld = (zerrQ.size() > 0) && (zerrQ[0] == cyc);
        checkCount++;
        if (o_zerror_vld !== expVld) begin
          failCount++;
          $display("[TB] FAIL zerror_vld pass%0d cyc%0d: got %b, required %b", pass, cyc, o_zerror_vld, expVld);
        end
        if (expVld) begin
          void'(zerrQ.pop_front());
          checkCount++;
          if (o_zerror !== 32'h2E44_0000) begin
            failCount++;
            $display("[TB] FAIL zerror_data: got %h, required 2e440000", o_zerror);
          end
        end
        nextCycle();
      end
    end
    clearInputs();
    nextCycle();
  endtask

  task automatic test_collision();
    i_tap_enable = 1; i_error_phase = 2'd1; i_error_sub_address = 32'h55; i_error_value = 32'h5EB0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      i_error_update_latch = (cyc == 0);
      i_tap_address = 4'd7;
      i_error_valid = (cyc == 1) || (cyc == 5);
      @(negedge clk);
      if (cyc == 1) begin
        checkCount++;
        if (o_tap_sub_vld !== 1'b1 || o_tap_wr_vld !== 1'b1 || o_tap_wr_addr !== 4'd13 ||
            o_tap_sub_addr !== 32'h55 || o_tap_sub_data !== 32'h5EB0) begin
          failCount++;
          $display("[TB] FAIL sub_write: got sub_vld=%b wr_vld=%b addr=%0d sub_addr=%h, required 1 1 13 55",
                   o_tap_sub_vld, o_tap_wr_vld, o_tap_wr_addr, o_tap_sub_addr);
        end
      end
      if (cyc == 5) begin
        checkCount++;
        if (o_tap_sub_vld !== 1'b0 || o_tap_wr_vld !== 1'b1 || o_tap_wr_addr !== 4'd7) begin
          failCount++;
          $display("[TB] FAIL collision_port: got sub_vld=%b wr_vld=%b addr=%0d, required 0 1 7",
                   o_tap_sub_vld, o_tap_wr_vld, o_tap_wr_addr);
        end
      end
      checkCount++;
      if (o_wb_collision !== (cyc >= 6)) begin
        failCount++;
        $display("[TB] FAIL collision_flag cyc%0d: got %b, required %b", cyc, o_wb_collision, (cyc >= 6));
      end
      nextCycle();
    end
    clearInputs();
    nextCycle();
  endtask

  task automatic test_output();
    logic expOvf;
    logic expVld;
    logic doPop;
    int   mCount;
    i_active_pre = 1; i_st_data_out_pre = 32'h0000_0BEE;
    #1;
    checkCount++;
    if (o_out_pre !== 32'h0000_0BEE || o_out_pre_vld !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL out_pre: got %h vld=%b, required 00000bee 1", o_out_pre, o_out_pre_vld);
    end
    i_active_pre = 0;
`ifdef NN_STAGE_OUT_SKID_EN
    expOvf = 0;
    mCount = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      i_active = (cyc < 3) || (cyc >= 6 && cyc < 9);
      i_out_rdy = (cyc >= 3 && cyc < 6) || (cyc >= 8);
      i_st_data_out = cyc + 1;
      expVld = (mCount > 0);
      doPop = expVld && i_out_rdy;
      @(negedge clk);
      checkCount++;
      if (o_out_vld !== expVld || o_out_overflow !== expOvf) begin
        failCount++;
        $display("[TB] FAIL skid_status cyc%0d: got vld=%b ovf=%b, required %b %b",
                 cyc, o_out_vld, o_out_overflow, expVld, expOvf);
      end
      if (expVld) begin
        checkCount++;
        if (o_out_data !== outQ[0]) begin
          failCount++;
          $display("[TB] FAIL skid_data cyc%0d: got %0d, required %0d", cyc, o_out_data, outQ[0]);
        end
      end
      if (doPop) begin
        void'(outQ.pop_front());
        mCount--;
      end
      if (i_active) begin
        if (mCount < 2) begin
          outQ.push_back(i_st_data_out);
          mCount++;
        end else begin
          expOvf = 1;
        end
      end
      nextCycle();
    end
    checkCount++;
    if (outQ.size() != 0 || o_out_vld !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL skid_drain: got %0d pending vld=%b, required 0 0", outQ.size(), o_out_vld);
    end
`else
    expOvf = 0; expVld = 1; doPop = 0; mCount = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      i_active = (cyc != 1);
      i_out_rdy = (cyc == 2);
      i_st_data_out = 32'hAB00 + cyc;
      expVld = i_active;
      #1;
      checkCount++;
      if (o_out_vld !== expVld || o_out_data !== 32'hAB00 + cyc || o_out_overflow !== expOvf) begin
        failCount++;
        $display("[TB] FAIL out_pass cyc%0d: got data=%h vld=%b ovf=%b, required %h %b 0",
                 cyc, o_out_data, o_out_vld, o_out_overflow, 32'hAB00 + cyc, expVld);
      end
      nextCycle();
    end
`endif
    clearInputs();
    nextCycle();
  endtask

  task automatic test_reset_midflight();
    i_tap_enable = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      i_error_update_latch = (cyc < 3);
      i_tap_address = 4'd4;
      reset = (cyc == 3 || cyc == 4);
      @(negedge clk);
      if (cyc >= 3) begin
        checkCount++;
        if (o_tap_wr_vld !== 1'b0 || o_bias_wr_vld !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL reset_flush cyc%0d: got wr_vld=%b bias_vld=%b, required 0 0",
                   cyc, o_tap_wr_vld, o_bias_wr_vld);
        end
      end
      if (cyc == 5) begin
        checkCount++;
        if (o_wb_collision !== 1'b0 || o_out_overflow !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL reset_sticky: got coll=%b ovf=%b, required 0 0", o_wb_collision, o_out_overflow);
        end
      end
      nextCycle();
    end
    reset = 0;
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_tap_read();
    test_writeback();
    test_zerror();
    test_collision();
    test_output();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/nn_stage_out_ctrl.md
# nn_stage_out_ctrl

Parametrised output/memory controller for one neural-network stage. It drives the data, tap and bias memory ports, and runs the delayed tap write-back pipeline. It generates the error-output valid, and registers the stage data output through an optional ready/valid skid buffer. It sits between the stage datapath (MAC/tap-update core) and the memories and downstream stage. It generalises the fixed 6-tap / 4-bit-address stage controller to arbitrary tap count, address width and pipeline latencies, and adds write-collision and output-overflow reporting.

## Interface
Parameters:
- WORD_W, 32, float word width.
- NTAPS, 6, taps per tap-memory row; row width = NTAPS*WORD_W.
- TAP_AW, 4, tap/bias memory address width.
- DATA_AW, 6, data memory address width.
- PHASE_W, 2, error phase width.
- ERR_BASE, 12, first tap-memory row holding error accumulators; ERR_BASE + 2^PHASE_W - 1 must be ≤ 2^TAP_AW - 1.
- TAP_LAT, 5, tap-update datapath latency (≥2).
- ERR_LAT, 10, error-output latency (≥1).

Ports (clock and reset first):
- clk in 1: clock.
- reset in 1: reset, synchronous, active-high.
- active, active_pre, active_normal, active_start_d in 1: stage sequencer status.
- data_valid in 1, data_write_addr in DATA_AW, data_value in WORD_W: input-sample write.
- data_read_addr in DATA_AW: data read address.
- tap_address in TAP_AW, tap_enable in 1, bias_enable in 1, bias_wr_address in TAP_AW: tap/bias control.
- error_update_first, error_update_latch, error_tap_update_out, error_valid in 1: error-path control.
- error_phase, error_phase_read in PHASE_W; error_sub_address in 32; error_value in WORD_W.
- st_data_out, st_data_out_pre, st_data_out_bias in WORD_W; st_tap_out in NTAPS*WORD_W: datapath results.
- tap_rd_data in NTAPS*WORD_W, data_rd_data in WORD_W, bias_rd_data in WORD_W: memory read data.
- data_wr_vld/out 1, data_wr_addr/out DATA_AW, data_wr_data/out WORD_W, data_rd_vld/out 1, data_rd_addr/out DATA_AW.
- tap_rd_vld/out 1, tap_rd_addr/out TAP_AW, tap_wr_vld/out 1, tap_wr_addr/out TAP_AW, tap_wr_data/out NTAPS*WORD_W.
- tap_sub_vld/out 1, tap_sub_addr/out 32, tap_sub_data/out WORD_W.
- bias_rd_vld, bias_wr_vld out 1; bias_rd_addr, bias_wr_addr out TAP_AW; bias_wr_data out WORD_W.
- taps out NTAPS*WORD_W; st_data, st_bias out WORD_W: unpacked operands to datapath.
- out_data out WORD_W, out_vld out 1, out_rdy in 1: stage output.
- out_pre out WORD_W, out_pre_vld out 1: pre-activation output.
- zerror out WORD_W, zerror_vld out 1: error output.
- wb_collision out 1, out_overflow out 1: sticky status flags.

## Operation
- Data memory: wr_vld=data_valid, wr_addr/wr_data pass through. rd_vld=active_normal, rd_addr=data_read_addr.
- Tap read: rd_addr = error_update_first ? ERR_BASE+error_phase_read (zero-extended) : tap_address. rd_vld=active_normal. bias_rd_addr=tap_address, bias_rd_vld=tap_rd_vld.
- Write-back request wb = error_update_latch & ~error_update_first. wb, tap_rd_addr and error_tap_update_out enter TAP_LAT-deep shift registers (wb_d[k], addr_d[k], upd_d[k]).
- tap_wr_addr = wb_d[TAP_LAT] ? addr_d[TAP_LAT] : ERR_BASE+error_phase. tap_wr_vld = error_valid | (tap_enable & wb_d[TAP_LAT] & ~upd_d[TAP_LAT]). tap_wr_data = st_tap_out.
- tap_sub_vld = wb_d[TAP_LAT] ? 0 : error_valid. Sub addr/data pass through.
- Collision: error_valid & wb_d[TAP_LAT] in the same cycle. Write-back wins and the sub-write is dropped; wb_collision sets, sticky until reset.
- bias_wr_vld = bias_enable & wb_d[TAP_LAT-1]; bias_wr_addr=bias_wr_address; bias_wr_data=st_data_out_bias.
- taps[i*WORD_W +: WORD_W] = tap_rd_data[i*WORD_W +: WORD_W]; st_data=data_rd_data; st_bias=bias_rd_data.
- out_pre=st_data_out_pre, out_pre_vld=active_pre (combinational).
- zerror=st_data_out_pre. zerror_vld = upd_e[ERR_LAT] & ~first_d, where upd_e is an ERR_LAT-deep delay of error_tap_update_out and first_d is active_start_d registered once.

## Timing
- All shift registers, first_d, flags and skid state clear to 0 on reset. Consequently tap_wr_vld, tap_sub_vld, bias_wr_vld and zerror_vld are driven only by their live inputs in the first cycles after reset.
- Write-back: wb at cycle t produces tap_wr at t+TAP_LAT and bias_wr at t+TAP_LAT-1.
- zerror_vld latency is ERR_LAT cycles.
- Reset mid-pipeline: all in-flight write-backs are discarded and no write is issued after reset.
- Skid buffer (when enabled) holds 2 entries:
  - Push when active; pop when out_vld & out_rdy. Simultaneous push and pop with count=2 is legal, and count is unchanged.
  - Push with count=2 and no pop: data is dropped and out_overflow sets (sticky).
  - Entering an empty buffer gives out_vld the cycle after push. FIFO order.

## Configuration
- NN_STAGE_OUT_SKID_EN defined: output passes through the 2-entry skid buffer above, and out_rdy is honoured.
- Not defined: out_data=st_data_out and out_vld=active combinationally. out_rdy is ignored and out_overflow is tied to 0.

## Test plan
- Reset, then tap_address=3, active_normal=1 → tap_rd_addr=3, tap_rd_vld=1. Set error_update_first=1, error_phase_read=2 → tap_rd_addr=14.
- Defaults: pulse error_update_latch at cycle 10 with tap_address=7 and tap_enable=1 → tap_wr_vld=1 and tap_wr_addr=7 at cycle 15; bias_wr_vld=1 at cycle 14.
- Same as above but with error_valid=1 at cycle 15 → tap_sub_vld=0, tap_wr_addr=7, and wb_collision=1 from cycle 16.
- error_tap_update_out pulse at cycle 20 with active_start_d=0 → zerror_vld=1 at cycle 30 only. Repeat with active_start_d=1 held → zerror_vld stays 0.
- Skid enabled: out_rdy=0, active high for 3 cycles with data 1,2,3 → out_vld=1, out_data=1, 3 dropped, out_overflow=1. Then out_rdy=1 → out_data 1 then 2, and out_vld falls.
- Assert reset with 3 write-backs in flight → no tap_wr_vld in the following TAP_LAT cycles.
